// File: rtl/seq_det_rr_sched.sv
// Round-robin scheduler sharing one overlapping serial pattern matcher between
// N_REQ bit-stream requesters; one requester owns the matcher for a whole frame.
module seq_det_rr_sched #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PAT_W = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
   parameter int unsigned CNT_W = 8,
   localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_REQ-1:0] req_valid,
   input  logic [N_REQ-1:0] req_bit,
   input  logic [N_REQ-1:0] req_last,
   output logic [N_REQ-1:0] req_ready,
   output logic             match_valid,
   output logic [ID_W-1:0]  match_id,
   output logic             frame_done,
   output logic [ID_W-1:0]  frame_id,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]       state, state_d;
   logic [ID_W-1:0]  rr_ptr, rr_ptr_d;
   logic [ID_W-1:0]  grant, grant_d;
   logic [PAT_W-1:0] hist, hist_d, hist_new;
   logic [FILL_W-1:0] fill, fill_d, fill_new;
   logic [CNT_W-1:0] cnt, cnt_d, cnt_new;
   logic [N_REQ-1:0] ready_d;
   logic             match_valid_d, frame_done_d;
   logic [ID_W-1:0]  match_id_d, frame_id_d;
   logic [CNT_W-1:0] frame_cnt_d;
   logic             found, hit, accept;
   logic [ID_W-1:0]  sel, cand;
   int unsigned      idx;

   // Registers: FSM state, arbitration pointer, matcher datapath and outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_IDLE;
         rr_ptr      <= ID_W'(N_REQ - 1);
         grant       <= '0;
         hist        <= '0;
         fill        <= '0;
         cnt         <= '0;
         req_ready   <= '0;
         match_valid <= 1'b0;
         match_id    <= '0;
         frame_done  <= 1'b0;
         frame_id    <= '0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_d;
         rr_ptr      <= rr_ptr_d;
         grant       <= grant_d;
         hist        <= hist_d;
         fill        <= fill_d;
         cnt         <= cnt_d;
         req_ready   <= ready_d;
         match_valid <= match_valid_d;
         match_id    <= match_id_d;
         frame_done  <= frame_done_d;
         frame_id    <= frame_id_d;
         frame_cnt   <= frame_cnt_d;
      end
   end

   // Next state, arbitration and per-beat match evaluation
   always_comb begin
      state_d       = state;
      rr_ptr_d      = rr_ptr;
      grant_d       = grant;
      hist_d        = hist;
      fill_d        = fill;
      cnt_d         = cnt;
      ready_d       = req_ready;
      match_valid_d = 1'b0;
      match_id_d    = match_id;
      frame_done_d  = 1'b0;
      frame_id_d    = frame_id;
      frame_cnt_d   = frame_cnt;
      found         = 1'b0;
      sel           = '0;
      cand          = '0;
      idx           = 0;

      // First valid requester strictly after the pointer, wrapping
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx  = (32'(rr_ptr) + i) % N_REQ;
         cand = ID_W'(idx);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end

      hist_new = PAT_W'({hist, req_bit[grant]});
      fill_new = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
      hit      = (hist_new == PATTERN) && (fill_new == FILL_W'(PAT_W));
      cnt_new  = (hit && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
      accept   = req_valid[grant] & req_ready[grant];

      case (state)
         S_IDLE: begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            if (found) begin
               grant_d = sel;
               state_d = S_BUSY;
               ready_d = N_REQ'(1) << sel;
            end
         end
         S_BUSY: begin
            if (accept) begin
               hist_d = hist_new;
               fill_d = fill_new;
               cnt_d  = cnt_new;
               if (hit) begin
                  match_valid_d = 1'b1;
                  match_id_d    = grant;
               end
               if (req_last[grant]) begin
                  frame_done_d = 1'b1;
                  frame_id_d   = grant;
                  frame_cnt_d  = cnt_new;
                  rr_ptr_d     = grant;
                  state_d      = S_IDLE;
                  ready_d      = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            ready_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Directed bench for seq_det_rr_sched: arbitration order, overlap matching,
// stalls, count saturation (CNT_W=2) and mid-frame reset.
module tb_seq_det_rr_sched;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned ID_W  = 2;

   logic             clk;
   logic             rstn;
   logic [N_REQ-1:0] req_valid, req_bit, req_last, req_ready;
   logic             match_valid, frame_done;
   logic [ID_W-1:0]  match_id, frame_id;
   logic [CNT_W-1:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int match_q[$];
   int fid_q[$];
   int fcnt_q[$];
   int grant_q[$];
   int gap_q[$];
   int multi_ready = 0;
   int idle_run    = 0;
   logic [N_REQ-1:0] prev_ready;

   seq_det_rr_sched #(
      .N_REQ(N_REQ), .PAT_W(4), .PATTERN(4'b1001), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_bit(req_bit), .req_last(req_last),
      .req_ready(req_ready),
      .match_valid(match_valid), .match_id(match_id),
      .frame_done(frame_done), .frame_id(frame_id), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observe outputs away from the rising edge
   always @(negedge clk) begin
      if (!rstn) begin
         prev_ready = '0;
         idle_run   = 0;
      end else begin
         if (match_valid) match_q.push_back(int'(match_id));
         if (frame_done) begin
            fid_q.push_back(int'(frame_id));
            fcnt_q.push_back(int'(frame_cnt));
         end
         if ($countones(req_ready) > 1) multi_ready++;
         if (req_ready == '0) idle_run++;
         else if (prev_ready == '0) begin
            for (int i = 0; i < N_REQ; i++)
               if (req_ready[i]) grant_q.push_back(i);
            gap_q.push_back(idle_run);
            idle_run = 0;
         end
         prev_ready = req_ready;
      end
   end

   task automatic clear_mon();
      @(posedge clk);
      match_q.delete(); fid_q.delete(); fcnt_q.delete();
      grant_q.delete(); gap_q.delete();
   endtask

   task automatic wait_ready(input int id);
      int t = 0;
      while (!req_ready[id] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready[id]) check($sformatf("timeout_ready%0d", id), 32'(req_ready[id]), 1);
   endtask

   // Send n bits MSB first; optionally drop valid for stall_len cycles before beat stall_at
   task automatic send(input int id, input logic [15:0] bits, input int n,
                       input int stall_at, input int stall_len);
      for (int k = 0; k < n; k++) begin
         if (k == stall_at) begin
            req_valid[id] = 1'b0;
            repeat (stall_len) @(negedge clk);
         end
         req_valid[id] = 1'b1;
         req_bit[id]   = bits[n-1-k];
         req_last[id]  = (k == n - 1);
         wait_ready(id);
         @(negedge clk);
      end
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
      req_bit[id]   = 1'b0;
   endtask

   task automatic check_frames(input string t, input int n, input int ids[8], input int cnts[8]);
      check({t, "_nframes"}, fid_q.size(), n);
      for (int i = 0; i < n && i < fid_q.size(); i++) begin
         check($sformatf("%s_fid%0d", t, i), fid_q[i], ids[i]);
         check($sformatf("%s_fcnt%0d", t, i), fcnt_q[i], cnts[i]);
      end
   endtask

   task automatic check_matches(input string t, input int n, input int ids[8]);
      check({t, "_nmatch"}, match_q.size(), n);
      for (int i = 0; i < n && i < match_q.size(); i++)
         check($sformatf("%s_mid%0d", t, i), match_q[i], ids[i]);
   endtask

   task automatic check_grants(input string t, input int n, input int ids[8]);
      check({t, "_ngrant"}, grant_q.size(), n);
      for (int i = 0; i < n && i < grant_q.size(); i++)
         check($sformatf("%s_gnt%0d", t, i), grant_q[i], ids[i]);
   endtask

   task automatic check_reset_outputs(input string t);
      check({t, "_ready"}, 32'(req_ready), 0);
      check({t, "_mvalid"}, 32'(match_valid), 0);
      check({t, "_mid"}, 32'(match_id), 0);
      check({t, "_fdone"}, 32'(frame_done), 0);
      check({t, "_fid"}, 32'(frame_id), 0);
      check({t, "_fcnt"}, 32'(frame_cnt), 0);
   endtask

   initial begin
      rstn = 1'b0;
      req_valid = '0; req_bit = '0; req_last = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rstn = 1'b1;
      @(negedge clk);

      // Test 3: all four requesters valid from reset, 3-bit frames
      clear_mon();
      @(negedge clk);
      fork
         begin
            send(0, 16'b100, 3, -1, 0);
            send(0, 16'b010, 3, -1, 0);
         end
         send(1, 16'b110, 3, -1, 0);
         send(2, 16'b011, 3, -1, 0);
         send(3, 16'b101, 3, -1, 0);
      join
      repeat (2) @(negedge clk);
      check_grants("t3", 5, '{0, 1, 2, 3, 0, 0, 0, 0});
      check_frames("t3", 5, '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
      check_matches("t3", 0, '{0, 0, 0, 0, 0, 0, 0, 0});
      check("t3_ngap", gap_q.size(), 5);
      for (int i = 1; i < 5 && i < gap_q.size(); i++)
         check($sformatf("t3_gap%0d", i), gap_q[i], 1);

      // Test 1: req0 sends 1001, ready appears the cycle after arbitration
      clear_mon();
      @(negedge clk);
      req_valid[0] = 1'b1; req_bit[0] = 1'b1; req_last[0] = 1'b0;
      check("t1_ready_idle", 32'(req_ready), 0);
      @(negedge clk);
      check("t1_ready_grant", 32'(req_ready), 32'b0001);
      send(0, 16'b1001, 4, -1, 0);
      repeat (2) @(negedge clk);
      check_matches("t1", 1, '{0, 0, 0, 0, 0, 0, 0, 0});
      check_frames("t1", 1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0});

      // Test 2: req1 sends 1001001, overlapping matches
      clear_mon();
      @(negedge clk);
      send(1, 16'b1001001, 7, -1, 0);
      repeat (2) @(negedge clk);
      check_matches("t2", 2, '{1, 1, 0, 0, 0, 0, 0, 0});
      check_frames("t2", 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0});

      // Test 4: req2 stalls 5 cycles mid-frame while req0 waits
      clear_mon();
      @(negedge clk);
      fork
         send(2, 16'b1001, 4, 2, 5);
         begin
            @(negedge clk);
            wait_ready(2);
            send(0, 16'b110, 3, -1, 0);
         end
      join
      repeat (2) @(negedge clk);
      check_grants("t4", 2, '{2, 0, 0, 0, 0, 0, 0, 0});
      check_matches("t4", 1, '{2, 0, 0, 0, 0, 0, 0, 0});
      check_frames("t4", 2, '{2, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0});

      // Test 5: four overlapping matches saturate a 2-bit count at 3
      clear_mon();
      @(negedge clk);
      send(1, 16'b1001001001001, 13, -1, 0);
      repeat (2) @(negedge clk);
      check_matches("t5", 4, '{1, 1, 1, 1, 0, 0, 0, 0});
      check_frames("t5", 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{3, 0, 0, 0, 0, 0, 0, 0});

      // Test 6: reset after two beats of a req3 frame
      clear_mon();
      @(negedge clk);
      req_valid[3] = 1'b1; req_bit[3] = 1'b1; req_last[3] = 1'b0;
      wait_ready(3);
      @(negedge clk);
      req_bit[3] = 1'b0;
      @(negedge clk);
      check("t6_ready_pre", 32'(req_ready), 32'b1000);
      rstn = 1'b0;
      req_valid = '0; req_bit = '0; req_last = '0;
      #1;
      check_reset_outputs("t6_rst");
      repeat (2) @(negedge clk);
      check("t6_no_done", fid_q.size(), 0);
      rstn = 1'b1;
      clear_mon();
      @(negedge clk);
      fork
         send(0, 16'b001, 3, -1, 0);
         send(2, 16'b1001, 4, -1, 0);
      join
      repeat (2) @(negedge clk);
      check_grants("t6", 2, '{0, 2, 0, 0, 0, 0, 0, 0});
      check_frames("t6", 2, '{0, 2, 0, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0, 0});
      check_matches("t6", 1, '{2, 0, 0, 0, 0, 0, 0, 0});

      check("one_hot_ready", multi_ready, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
